// File: rtl/dat_line_seq_if.sv
// Handshake and RAM-side bundle for the line sequencer.
// slave is the sequencer's view; master is the controller/memory/RAM side.
interface dat_line_seq_if #(
  parameter int WAYS_N  = 4,
  parameter int WORDS_N = 8,
  parameter int DATA_W  = 32,
  parameter int SET_W   = 6
);
  localparam int ADDR_W = SET_W + $clog2(WORDS_N);

  logic                       req_vld;
  logic                       req_rdy;
  logic                       req_op;
  logic [WAYS_N-1:0]          req_way;
  logic [SET_W-1:0]           req_set;
  logic                       fill_vld;
  logic                       fill_rdy;
  logic [DATA_W-1:0]          fill_data;
  logic                       evict_vld;
  logic                       evict_rdy;
  logic [DATA_W-1:0]          evict_data;
  logic                       evict_last;
  logic [WAYS_N-1:0]          ram_en;
  logic [WAYS_N-1:0]          ram_wen;
  logic [ADDR_W-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_wdata;
  logic [WAYS_N*DATA_W-1:0]   ram_rdata;
  logic                       done_vld;
  logic                       done_op;

  modport master (
    output req_vld, req_op, req_way, req_set, fill_vld, fill_data, evict_rdy, ram_rdata,
    input  req_rdy, fill_rdy, evict_vld, evict_data, evict_last,
           ram_en, ram_wen, ram_addr, ram_wdata, done_vld, done_op
  );

  modport slave (
    input  req_vld, req_op, req_way, req_set, fill_vld, fill_data, evict_rdy, ram_rdata,
    output req_rdy, fill_rdy, evict_vld, evict_data, evict_last,
           ram_en, ram_wen, ram_addr, ram_wdata, done_vld, done_op
  );
endinterface

// File: rtl/dat_line_seq.sv
// Line sequencer for the per-way data RAMs: FILL writes a line beat by beat,
// EVICT reads a line through a 2-entry fall-through buffer under backpressure.
//
// state | meaning
// IDLE  | waiting for a line request, req_rdy high
// FILL  | one RAM write per accepted fill beat
// EVICT | credit-limited RAM reads, beats streamed to write-back
// DONE  | one-cycle completion pulse
module dat_line_seq #(
  parameter int WAYS_N  = 4,
  parameter int WORDS_N = 8,
  parameter int DATA_W  = 32,
  parameter int SET_W   = 6
) (
  input logic            clk,
  input logic            rst,
  dat_line_seq_if.slave  bus
);
  localparam int WRD_W  = $clog2(WORDS_N);
  localparam int CNT_W  = WRD_W + 1;
  localparam int ADDR_W = SET_W + WRD_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_N);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     op_q;
  logic [WAYS_N-1:0]        way_q;
  logic [SET_W-1:0]         set_q;
  logic [CNT_W-1:0]         wcnt_q, rcnt_q, pcnt_q;
  logic                     inflight_q;
  logic [1:0][DATA_W-1:0]   fifo_mem_q;
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               fifo_cnt_q;

  logic                     req_rdy, fill_rdy, evict_vld, evict_last, done_vld, done_op;
  logic [DATA_W-1:0]        evict_data, ram_wdata, rd_word;
  logic [WAYS_N-1:0]        ram_en, ram_wen;
  logic [ADDR_W-1:0]        ram_addr;
  logic                     accept, fill_fire, rd_issue, pop, fifo_pop, push;
  logic [2:0]               credit;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WAYS_N; i++) begin
      if (way_q[i]) rd_word = rd_word | bus.ram_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_rdy    = 1'b0;
    fill_rdy   = 1'b0;
    evict_vld  = 1'b0;
    evict_data = '0;
    evict_last = 1'b0;
    ram_en     = '0;
    ram_wen    = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    done_vld   = 1'b0;
    done_op    = 1'b0;
    accept     = 1'b0;
    fill_fire  = 1'b0;
    rd_issue   = 1'b0;
    pop        = 1'b0;
    credit     = '0;
    case (state_q)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_vld) begin
          accept  = 1'b1;
          state_d = bus.req_op ? S_EVICT : S_FILL;
        end
      end
      S_FILL: begin
        fill_rdy = 1'b1;
        if (bus.fill_vld) begin
          fill_fire = 1'b1;
          ram_en    = way_q;
          ram_wen   = way_q;
          ram_addr  = {set_q, wcnt_q[WRD_W-1:0]};
          ram_wdata = bus.fill_data;
          if (wcnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_EVICT: begin
        // Read data in flight is presented straight away when the buffer is empty.
        evict_vld  = (fifo_cnt_q != 2'd0) || inflight_q;
        evict_data = (fifo_cnt_q != 2'd0) ? fifo_mem_q[rd_ptr_q] : rd_word;
        evict_last = evict_vld && (pcnt_q == CNT_LAST);
        pop        = evict_vld && bus.evict_rdy;
        credit     = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        if ((rcnt_q < CNT_FULL) && (credit < 3'd2)) begin
          rd_issue = 1'b1;
          ram_en   = way_q;
          ram_addr = {set_q, rcnt_q[WRD_W-1:0]};
        end
        if (pop && (pcnt_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        done_vld = 1'b1;
        done_op  = op_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_pop = pop && (fifo_cnt_q != 2'd0);
  assign push     = inflight_q && !(pop && (fifo_cnt_q == 2'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 1'b0;
      way_q      <= '0;
      set_q      <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      pcnt_q     <= '0;
      inflight_q <= 1'b0;
      fifo_mem_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      inflight_q <= rd_issue;
      if (accept) begin
        op_q   <= bus.req_op;
        way_q  <= bus.req_way;
        set_q  <= bus.req_set;
        wcnt_q <= '0;
        rcnt_q <= '0;
        pcnt_q <= '0;
      end
      if (fill_fire) wcnt_q <= wcnt_q + CNT_W'(1);
      if (rd_issue)  rcnt_q <= rcnt_q + CNT_W'(1);
      if (pop)       pcnt_q <= pcnt_q + CNT_W'(1);
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= rd_word;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
      else if (fifo_pop && !push) fifo_cnt_q <= fifo_cnt_q - 2'd1;
    end
  end

  assign bus.req_rdy    = req_rdy;
  assign bus.fill_rdy   = fill_rdy;
  assign bus.evict_vld  = evict_vld;
  assign bus.evict_data = evict_data;
  assign bus.evict_last = evict_last;
  assign bus.ram_en     = ram_en;
  assign bus.ram_wen    = ram_wen;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.done_vld   = done_vld;
  assign bus.done_op    = done_op;

  a_way_onehot: assert property (@(posedge clk) disable iff (!rst)
    (bus.req_vld && req_rdy) |-> $onehot0(bus.req_way));
endmodule

// File: tb/tb_dat_line_seq.sv
// Directed bench for dat_line_seq with a behavioural per-way RAM behind it.
module tb_dat_line_seq;
  localparam int WAYS_N  = 4;
  localparam int WORDS_N = 8;
  localparam int DATA_W  = 32;
  localparam int SET_W   = 6;
  localparam int ADDR_W  = SET_W + $clog2(WORDS_N);

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  dat_line_seq_if #(.WAYS_N(WAYS_N), .WORDS_N(WORDS_N), .DATA_W(DATA_W), .SET_W(SET_W)) bus ();

  dat_line_seq #(.WAYS_N(WAYS_N), .WORDS_N(WORDS_N), .DATA_W(DATA_W), .SET_W(SET_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one read-data register per way.
  logic [DATA_W-1:0]        mem [WAYS_N][1<<ADDR_W];
  logic [WAYS_N*DATA_W-1:0] rdata_q;

  always @(posedge clk) begin
    for (int i = 0; i < WAYS_N; i++) begin
      if (bus.ram_en[i]) begin
        if (bus.ram_wen[i]) mem[i][bus.ram_addr] <= bus.ram_wdata;
        else                rdata_q[i*DATA_W +: DATA_W] <= mem[i][bus.ram_addr];
      end
    end
  end
  assign bus.ram_rdata = rdata_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic fill_line(input logic [3:0] way, input logic [5:0] set,
                           input logic [31:0] base, input bit gaps);
    int nw = 0;
    int k  = 0;
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_op = 1'b0; bus.req_way = way; bus.req_set = set;
    #1 check("fill_req_rdy", bus.req_rdy, 1);
    @(negedge clk);
    bus.req_vld = 1'b0;
    while (nw < WORDS_N && k < 40) begin
      bus.fill_vld  = gaps ? (k % 2 == 0) : 1'b1;
      bus.fill_data = base + nw;
      #1;
      check("fill_rdy", bus.fill_rdy, 1);
      check("fill_no_done", bus.done_vld, 0);
      if (bus.fill_vld) begin
        check("fill_en", bus.ram_en, way);
        check("fill_wen", bus.ram_wen, way);
        check("fill_addr", bus.ram_addr, {set, 3'(nw)});
        check("fill_wdata", bus.ram_wdata, base + nw);
        nw++;
      end else begin
        check("fill_idle_en", bus.ram_en, 0);
      end
      k++;
      @(negedge clk);
    end
    check("fill_beats", nw, WORDS_N);
    bus.fill_vld = 1'b0;
    #1;
    check("fill_done_vld", bus.done_vld, 1);
    check("fill_done_op", bus.done_op, 0);
    check("fill_done_en", bus.ram_en, 0);
    @(negedge clk);
    #1;
    check("fill_done_once", bus.done_vld, 0);
    check("fill_back_idle", bus.req_rdy, 1);
  endtask

  task automatic evict_line(input logic [3:0] way, input logic [5:0] set,
                            input logic [31:0] base, input int pct);
    int issued   = 0;
    int npop     = 0;
    int done_cyc = 0;
    logic stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_op = 1'b1; bus.req_way = way; bus.req_set = set;
    #1 check("ev_req_rdy", bus.req_rdy, 1);
    @(negedge clk);
    bus.req_vld = 1'b0;
    for (int cyc = 1; cyc < 200 && done_cyc == 0; cyc++) begin
      bus.evict_rdy = ($urandom_range(0, 99) < pct);
      #1;
      if (cyc == 1) check("ev_lat_early", bus.evict_vld, 0);
      if (cyc == 2) check("ev_lat", bus.evict_vld, 1);
      if (bus.done_vld) begin
        done_cyc = cyc;
        check("ev_done_op", bus.done_op, 1);
        check("ev_beats", npop, WORDS_N);
        check("ev_reads", issued, (way == 0) ? 0 : WORDS_N);
      end else begin
        if (bus.ram_en != 0) begin
          check("ev_ren", bus.ram_en, way);
          check("ev_rwen", bus.ram_wen, 0);
          check("ev_raddr", bus.ram_addr, {set, 3'(issued)});
          issued++;
        end
        if (stall_prev) begin
          check("ev_hold_vld", bus.evict_vld, 1);
          check("ev_hold_data", bus.evict_data, prev_data);
        end
        if (bus.evict_vld) begin
          check("ev_last", bus.evict_last, npop == WORDS_N - 1);
          if (bus.evict_rdy) begin
            exp_d = (way == 0) ? 32'h0 : base + npop;
            check("ev_data", bus.evict_data, exp_d);
            npop++;
          end
        end
        check("ev_credit", (issued - npop) <= 2, 1);
        stall_prev = bus.evict_vld && !bus.evict_rdy;
        prev_data  = bus.evict_data;
      end
      @(negedge clk);
    end
    bus.evict_rdy = 1'b0;
    check("ev_done_seen", done_cyc != 0, 1);
    if (pct == 100) check("ev_stream_len", done_cyc, 10);
    #1;
    check("ev_done_once", bus.done_vld, 0);
    check("ev_back_idle", bus.req_rdy, 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.req_vld = 1'b0; bus.req_op = 1'b0; bus.req_way = '0; bus.req_set = '0;
    bus.fill_vld = 1'b0; bus.fill_data = '0; bus.evict_rdy = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_vld   = 1'($urandom_range(0, 1));
      bus.req_op    = 1'($urandom_range(0, 1));
      bus.req_way   = 4'(1 << $urandom_range(0, 3));
      bus.req_set   = 6'($urandom_range(0, 63));
      bus.fill_vld  = 1'($urandom_range(0, 1));
      bus.fill_data = $urandom;
      bus.evict_rdy = 1'($urandom_range(0, 1));
      #1;
      check("rst_req_rdy", bus.req_rdy, 1);
      check("rst_fill_rdy", bus.fill_rdy, 0);
      check("rst_evict_vld", bus.evict_vld, 0);
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_done_vld", bus.done_vld, 0);
    end
    @(negedge clk);
    bus.req_vld = 1'b0; bus.fill_vld = 1'b0; bus.evict_rdy = 1'b0;
    rst = 1'b1;

    fill_line(4'b0100, 6'h05, 32'hA0, 1'b0);
    fill_line(4'b0100, 6'h05, 32'hB0, 1'b1);
    fill_line(4'b0010, 6'h3F, 32'h10, 1'b0);
    evict_line(4'b0010, 6'h3F, 32'h10, 100);
    fill_line(4'b0001, 6'h12, 32'hC0, 1'b1);
    evict_line(4'b0001, 6'h12, 32'hC0, 30);
    evict_line(4'b0000, 6'h05, 32'hB0, 100);

    // Abort a FILL after three beats
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_op = 1'b0; bus.req_way = 4'b1000; bus.req_set = 6'h01;
    @(negedge clk);
    bus.req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.fill_vld  = 1'b1;
      bus.fill_data = 32'hD0 + i;
      @(negedge clk);
    end
    bus.fill_vld = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_req_rdy", bus.req_rdy, 1);
    check("abort_fill_rdy", bus.fill_rdy, 0);
    check("abort_done", bus.done_vld, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("abort_no_done", bus.done_vld, 0);
      check("abort_idle", bus.req_rdy, 1);
      @(negedge clk);
    end
    evict_line(4'b0100, 6'h05, 32'hB0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dat_line_seq.md
Name: dat_line_seq

Overview:
- Line-granular sequencer that sits directly upstream of the per-way data RAM array.
- Converts one-shot line requests from the cache controller into per-word RAM commands.
- FILL: writes WORDS_N beats arriving from the memory side into one way of one set.
- EVICT: reads all WORDS_N words of one way/set, buffers them, and streams them to the write-back path under backpressure.

Parameters:
- WAYS_N, 4, number of ways; width of the one-hot way select and the RAM enable vectors.
- WORDS_N, 8, words per cache line; power of two, >= 2.
- DATA_W, 32, RAM word width.
- SET_W, 6, set index width; RAM address is {set, word}, width SET_W+$clog2(WORDS_N).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_vld  in  1  line request valid.
- req_rdy  out  1  sequencer accepts a request.
- req_op  in  1  0 = FILL, 1 = EVICT.
- req_way  in  WAYS_N  one-hot target way.
- req_set  in  SET_W  target set.
- fill_vld  in  1  fill beat valid.
- fill_rdy  out  1  fill beat accepted.
- fill_data  in  DATA_W  fill beat payload.
- evict_vld  out  1  evict beat valid.
- evict_rdy  in  1  downstream accepts evict beat.
- evict_data  out  DATA_W  evict beat payload.
- evict_last  out  1  final beat of the line.
- ram_en  out  WAYS_N  per-way RAM enable.
- ram_wen  out  WAYS_N  per-way RAM write enable.
- ram_addr  out  SET_W+$clog2(WORDS_N)  RAM word address {set, word}.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  WAYS_N*DATA_W  per-way read data, valid 1 cycle after a read enable.
- done_vld  out  1  one-cycle pulse when the operation completes.
- done_op  out  1  op of the completed operation; valid with done_vld.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; evict FIFO empty.
- Reset output values: req_rdy=1 (combinational from IDLE); all other outputs 0.
- States: IDLE, FILL, EVICT, DONE.
- IDLE:
  - req_rdy=1.
  - On req_vld, capture op, way and set, clear counters, go to FILL or EVICT per op.
  - No RAM activity in IDLE.
- FILL:
  - fill_rdy=1.
  - On fill_vld & fill_rdy, in the same cycle (combinational): ram_en=ram_wen=way, ram_addr={set, wcnt}, ram_wdata=fill_data; then wcnt++.
  - Beat with wcnt==WORDS_N-1 goes to DONE.
  - Idle cycles (fill_vld=0) issue no RAM command.
- EVICT read issue:
  - Issue a read (ram_en=way, ram_wen=0, addr={set, rcnt}) when rcnt<WORDS_N and fifo_count + inflight < 2. Then rcnt++ and inflight=1 for the next cycle.
  - Read data is taken the following cycle as the AND-OR mux of ram_rdata by the one-hot way, and pushed into a 2-entry FIFO.
  - Credit rule: the FIFO must never overflow.
  - Zero-bubble throughput: with evict_rdy held high, one beat per cycle after 1-cycle initial latency. A pop in the same cycle frees credit for that cycle's issue.
- EVICT output:
  - evict_vld = FIFO non-empty; evict_data = FIFO head.
  - evict_last = (pcnt==WORDS_N-1) & evict_vld.
  - On evict_vld & evict_rdy, pop and pcnt++.
  - Once valid, evict_data/evict_last hold stable until popped.
  - Popping the last beat goes to DONE.
- DONE: done_vld=1, done_op=op for exactly one cycle, then IDLE. A new request can be accepted the cycle after DONE.
- Simultaneous FIFO push and pop: count unchanged; order preserved.
- req_way all-zero: no RAM enables are driven. FILL still consumes WORDS_N beats; EVICT returns WORDS_N zero beats. Non-one-hot req_way is illegal (assertion).
- Counters are $clog2(WORDS_N)+1 bits, so terminal counts need no wrap.
- rst asserted mid-operation: immediate abort to IDLE, FIFO flushed, no done pulse. A partial line in the RAM is the controller's responsibility.

Test Plan:
- Reset: rst low with random inputs -> req_rdy=1; fill_rdy, evict_vld, ram_en, done_vld all 0.
- FILL back-to-back: req op=0 way=4'b0100 set=0x05; 8 beats 0xA0..0xA7 on consecutive cycles -> ram_wen=4'b0100 on addr {5,0..7}, wdata 0xA0..0xA7; done_vld pulse the cycle after beat 7, done_op=0.
- FILL gaps: same request with fill_vld toggling 1/0 -> exactly 8 RAM writes with no duplicates; addresses are contiguous.
- EVICT streaming: RAM model preloaded way 1, set 0x3F with 0x10..0x17; evict_rdy=1 -> first evict_vld 2 cycles after accept, then 8 consecutive beats 0x10..0x17; evict_last on 0x17 only.
- EVICT backpressure: evict_rdy random at 30% -> data order is preserved, never more than 2 reads outstanding/buffered, payload held stable while stalled.
- Abort: rst low after 3 fill beats, then a new EVICT request -> no done pulse for the aborted FILL; the EVICT completes normally from word 0.
